// File: rtl/activation_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : activation_memory_pkg
// Description : Shared power-state encoding and address-split width helpers
//               for the banked activation memory.
// Revision    : 1.0 - initial release
// ============================================================================
package activation_memory_pkg;

    // Power-management states of the memory controller
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } power_state_t;

    // Full word-address width for a memory of num_rows words
    function automatic int addr_width(input int num_rows);
        return $clog2(num_rows);
    endfunction

    // Number of address bits that select a bank
    function automatic int bank_bits(input int num_banks);
        return $clog2(num_banks);
    endfunction

    // Number of address bits that select a row inside one bank
    function automatic int row_bits(input int num_rows, input int num_banks);
        return $clog2(num_rows) - $clog2(num_banks);
    endfunction

    // Zero-width fields are carried as one bit so they stay declarable
    function automatic int field_width(input int bits);
        return (bits > 0) ? bits : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/activation_memory_bank.sv
`default_nettype none
// ============================================================================
// Module      : activation_memory_bank
// Description : One bank of masked dual-port SRAM model. Single write port
//               with per-bit mask, single read port with one-cycle latency,
//               write-to-read forwarding on a same-row collision, and a
//               power-down input that blocks all accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module activation_memory_bank #(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 128,
    parameter int ROW_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             power_down,
    input  logic             write_enable,
    input  logic [ROW_W-1:0] write_row,
    input  logic [WIDTH-1:0] write_data,
    input  logic [WIDTH-1:0] write_mask,
    input  logic             read_enable,
    input  logic [ROW_W-1:0] read_row,
    output logic [WIDTH-1:0] read_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_read_data;

    logic             w_wr_en;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_merged;

    assign w_wr_en  = write_enable && !power_down;
    assign w_rd_en  = read_enable  && !power_down;
    // New word after a masked write: masked bits from write_data, rest kept
    assign w_merged = (write_data & write_mask) | (r_mem[write_row] & ~write_mask);

    // Array write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[write_row] <= w_merged;
        end
    end

    // Read port register; holds its value between reads, forwards merged word on collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= '0;
        end else if (w_rd_en) begin
            if (w_wr_en && (read_row == write_row)) begin
                r_read_data <= w_merged;
            end else begin
                r_read_data <= r_mem[read_row];
            end
        end
    end

    assign read_data = r_read_data;

endmodule
`default_nettype wire

// File: rtl/activation_memory_banked.sv
`default_nettype none
// ============================================================================
// Module      : activation_memory_banked
// Description : Banked activation memory with masked writes, one-cycle
//               registered reads, same-address write forwarding and an
//               ACTIVE/SLEEP/WAKE power-management state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module activation_memory_banked
    import activation_memory_pkg::*;
#(
    parameter int WIDTH       = 1024,
    parameter int NUM_ROWS    = 512,
    parameter int NUM_BANKS   = 4,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write_enable,
    input  logic [$clog2(NUM_ROWS)-1:0] write_address,
    input  logic [WIDTH-1:0]            write_data,
    input  logic [WIDTH-1:0]            write_mask,
    input  logic                        read_enable,
    input  logic [$clog2(NUM_ROWS)-1:0] read_address,
    output logic [WIDTH-1:0]            read_data,
    output logic                        read_data_valid,
    input  logic                        power_down,
    output logic                        ready,
    output logic                        sleeping
);

    localparam int ADDRESS_WIDTH = addr_width(NUM_ROWS);
    localparam int BANK_BITS     = bank_bits(NUM_BANKS);
    localparam int ROW_BITS      = row_bits(NUM_ROWS, NUM_BANKS);
    localparam int BANK_W        = field_width(BANK_BITS);
    localparam int ROW_W         = field_width(ROW_BITS);
    localparam int BANK_DEPTH    = NUM_ROWS / NUM_BANKS;
    localparam int WAKE_CNT_W    = $clog2(WAKE_CYCLES + 1);

    localparam logic [WAKE_CNT_W-1:0] c_wake_last = WAKE_CNT_W'(WAKE_CYCLES - 1);

    power_state_t          r_state;
    power_state_t          w_state_next;
    logic [WAKE_CNT_W-1:0] r_wake_cnt;
    logic [WAKE_CNT_W-1:0] w_wake_cnt_next;

    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_bank_pd;
    logic [BANK_W-1:0]     w_wr_bank;
    logic [BANK_W-1:0]     w_rd_bank;
    logic [ROW_W-1:0]      w_wr_row;
    logic [ROW_W-1:0]      w_rd_row;
    logic [BANK_W-1:0]     r_rd_bank;
    logic                  r_rd_valid;
    logic [WIDTH-1:0]      w_bank_rdata [NUM_BANKS];

    // Upper address bits pick the bank, lower bits pick the row inside it
    assign w_wr_bank = BANK_W'(write_address >> ROW_BITS);
    assign w_rd_bank = BANK_W'(read_address  >> ROW_BITS);
    assign w_wr_row  = ROW_W'(write_address);
    assign w_rd_row  = ROW_W'(read_address);

    // Requests are only accepted while fully awake and not being put to sleep
    assign ready       = (r_state == ACTIVE) && !power_down;
    assign sleeping    = (r_state == SLEEP);
    assign w_wr_accept = write_enable && ready;
    assign w_rd_accept = read_enable  && ready;

    // Banks stay powered down through the first WAKE cycle as well
    assign w_bank_pd = (r_state == SLEEP) || ((r_state == WAKE) && (r_wake_cnt == '0));

    // Power state and wake counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ACTIVE;
            r_wake_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wake_cnt <= w_wake_cnt_next;
        end
    end

    // Next power state; the counter only advances in WAKE and never passes its last value
    always_comb begin
        w_state_next    = r_state;
        w_wake_cnt_next = '0;
        case (r_state)
            ACTIVE: begin
                if (power_down) begin
                    w_state_next = SLEEP;
                end
            end
            SLEEP: begin
                if (!power_down) begin
                    w_state_next = WAKE;
                end
            end
            WAKE: begin
                if (power_down) begin
                    w_state_next = SLEEP;
                end else if (r_wake_cnt >= c_wake_last) begin
                    w_state_next = ACTIVE;
                end else begin
                    w_wake_cnt_next = r_wake_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ACTIVE;
            end
        endcase
    end

    // Read completion tracking: valid pulse and which bank holds the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_bank  <= '0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_bank <= w_rd_bank;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_we;
        logic w_re;

        assign w_we = w_wr_accept && (w_wr_bank == BANK_W'(b));
        assign w_re = w_rd_accept && (w_rd_bank == BANK_W'(b));

        activation_memory_bank #(
            .WIDTH (WIDTH),
            .DEPTH (BANK_DEPTH),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk          (clk),
            .rst          (rst),
            .power_down   (w_bank_pd),
            .write_enable (w_we),
            .write_row    (w_wr_row),
            .write_data   (write_data),
            .write_mask   (write_mask),
            .read_enable  (w_re),
            .read_row     (w_rd_row),
            .read_data    (w_bank_rdata[b])
        );
    end

    assign read_data       = w_bank_rdata[r_rd_bank];
    assign read_data_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: doc/activation_memory_banked.md
ACTIVATION_MEMORY_BANKED -- requirements
Module: activation_memory_banked

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, meaning word width in bits.
REQ-002 SHALL have parameter NUM_ROWS, default 512, meaning total words; power of two.
REQ-003 SHALL have parameter NUM_BANKS, default 4, meaning independent dual-port banks; power of two, divides NUM_ROWS.
REQ-004 SHALL have parameter WAKE_CYCLES, default 4, meaning cycles from power-up to access permitted; at least 1.
REQ-005 SHALL derive ADDRESS_WIDTH = clog2(NUM_ROWS), BANK_BITS = clog2(NUM_BANKS), ROW_BITS = ADDRESS_WIDTH - BANK_BITS.
REQ-006 SHALL have the ports below, clock and reset first; one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- write_enable  in  1  write request.
- write_address  in  ADDRESS_WIDTH  write word address.
- write_data  in  WIDTH  write data.
- write_mask  in  WIDTH  per-bit write enable; 1 = bit written.
- read_enable  in  1  read request.
- read_address  in  ADDRESS_WIDTH  read word address.
- read_data  out  WIDTH  registered read data.
- read_data_valid  out  1  one-cycle pulse; read_data is new.
- power_down  in  1  sleep request, level.
- ready  out  1  requests accepted this cycle.
- sleeping  out  1  all banks powered down.

Function
REQ-007 SHALL map address bits [ADDRESS_WIDTH-1:ROW_BITS] to bank index and [ROW_BITS-1:0] to row.
REQ-008 SHALL drive ready = (state == ACTIVE) && !power_down; requests seen while ready = 0 SHALL be dropped without side effect.
REQ-009 SHALL, on an accepted write, update only the addressed bank and only the bits where write_mask = 1; all other bits SHALL be preserved.
REQ-010 SHALL, on an accepted read, assert read_data_valid and present data exactly one cycle later.
REQ-011 SHALL hold read_data unchanged until the next read completes, including through SLEEP and WAKE.
REQ-012 SHALL, when a read and a write to the same address are accepted in the same cycle, return (write_data & write_mask) | (old & ~write_mask).
REQ-013 SHALL serve a read and a write to different addresses, in the same or different banks, in the same cycle with no stall.
REQ-014 SHALL enable only the addressed bank's read and write strobes; all other banks SHALL see no strobes.
REQ-015 SHALL implement FSM ACTIVE, SLEEP, WAKE with these transitions:
- ACTIVE to SLEEP when power_down = 1.
- SLEEP to WAKE when power_down = 0.
- WAKE to ACTIVE after WAKE_CYCLES cycles in WAKE.
- WAKE to SLEEP on the cycle power_down = 1; the wake counter SHALL clear.
REQ-016 SHALL assert bank power-down in SLEEP and WAKE's first cycle, and drive sleeping = (state == SLEEP).
REQ-017 SHALL complete a read accepted in the cycle before power_down rises: read_data_valid is still issued.
REQ-018 SHALL keep the wake counter at clog2(WAKE_CYCLES+1) bits, saturating, with no wrap.
REQ-019 SHALL not guarantee array contents after SLEEP; this is a retention-free model, and the bench SHALL not check them.

Reset
REQ-020 SHALL, on rst = 1, set state to ACTIVE, wake counter to 0, read_data to 0, and read_data_valid to 0; sleeping = 0 and ready follows REQ-008.
REQ-021 SHALL, on rst asserted mid-read, suppress the pending read_data_valid.
REQ-022 SHALL not reset the array contents.

Structure
REQ-023 SHALL place the FSM state enum (ACTIVE, SLEEP, WAKE) and the address-split helper widths in the shared package activation_memory_pkg.
REQ-024 SHALL instantiate NUM_BANKS copies of sub-module activation_memory_bank, a single-bank masked dual-port SRAM model with 1-cycle read latency and a power-down input.
REQ-025 SHALL have read-data bank select driven by the registered bank index of the previous accepted read.

Verification
REQ-026 SHALL cover masked write: write address 5, data all-ones, mask 0x...00FF over prior zeros; then read 5 -> read_data = 0x...00FF, valid one cycle after the request.
REQ-027 SHALL cover same-address collision: prior word 0xAA..., simultaneous write 0x55... with mask low half and read of that address -> merged word returned next cycle.
REQ-028 SHALL cover cross-bank parallelism: write bank 0 row 3 and read bank 3 row 3 in one cycle -> both complete, no ready drop.
REQ-029 SHALL cover power cycle with WAKE_CYCLES = 4: power_down high 3 cycles then low -> sleeping for 3 cycles, ready returns exactly 4 cycles after WAKE entry, read_data retained throughout.
REQ-030 SHALL cover wake abort: power_down reasserted on the 2nd WAKE cycle -> SLEEP next cycle; a subsequent full wake still takes 4 cycles.
REQ-031 SHALL cover reset mid-read: rst asserted the cycle after a read is accepted -> read_data_valid stays 0 and read_data = 0.
